// File: rtl/sid_bus_if_if.sv
// sid_bus_if_if: bundles the raw 6510-side pins and the registered bus-side
// outputs of sid_bus_if.
//   slave  : the front-end stage (pins in, phase/transaction/status out)
//   master : the pin driver / consumer side (pins out, everything else in)
// Pins:    phi2_x, cs_n_x (active low), rw_x (1 = read), addr_x[4:0], data_x[7:0]
// Outputs: phase[3:0] one-hot {PHI2_PHI1, PHI2, PHI1_PHI2, PHI1}, addr[4:0],
//          data[7:0], we, oe, data_oe, phi2_lost, short_err
interface sid_bus_if_if;
  logic       phi2_x;
  logic       cs_n_x;
  logic       rw_x;
  logic [4:0] addr_x;
  logic [7:0] data_x;
  logic [3:0] phase;
  logic [4:0] addr;
  logic [7:0] data;
  logic       we;
  logic       oe;
  logic       data_oe;
  logic       phi2_lost;
  logic       short_err;

  modport master (
    output phi2_x, cs_n_x, rw_x, addr_x, data_x,
    input  phase, addr, data, we, oe, data_oe, phi2_lost, short_err
  );

  modport slave (
    input  phi2_x, cs_n_x, rw_x, addr_x, data_x,
    output phase, addr, data, we, oe, data_oe, phi2_lost, short_err
  );
endinterface

// File: rtl/sid_bus_if.sv
// sid_bus_if: bus front end ahead of the SID core. Synchronises the raw 6510
// bus pins into clk, deglitches PHI2, tracks the bus cycle with a small FSM,
// emits one-hot sub-cycle strobes and captures the bus transaction at the
// PHI2 strobe. Also drives the data-bus transceiver enable with hold time.
// Ports:
//   clk  system clock (sole clock)
//   res  synchronous active-high reset
//   bus  sid_bus_if_if.slave: raw pins in; phase/addr/data/we/oe/data_oe/
//        phi2_lost/short_err out (all registered)
module sid_bus_if #(
  parameter int SYNC_STAGES  = 2,
  parameter int PHI2_FILTER  = 3,
  parameter int PHI2_SETTLE  = 8,
  parameter int DOUT_HOLD    = 4,
  parameter int PHI2_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        res,
  sid_bus_if_if.slave bus
);
  localparam int PW = 16;
  localparam int FW = $clog2(PHI2_FILTER + 1);
  localparam int HW = $clog2(DOUT_HOLD + 1);
  localparam logic [3:0] PH1  = 4'b0001;
  localparam logic [3:0] PH12 = 4'b0010;
  localparam logic [3:0] PH2  = 4'b0100;
  localparam logic [3:0] PH21 = 4'b1000;

  typedef enum logic [1:0] {SYNC, LOW, HIGH_WAIT, HIGH_DONE} state_t;

  // Pin synchroniser: all pins travel through the same flop chain so the
  // sampled bus fields stay aligned with the synchronised PHI2.
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic       phi2_s, cs_n_s, rw_s;
  logic [4:0] addr_s;
  logic [7:0] data_s;

  always_ff @(posedge clk) begin
    if (res) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {bus.phi2_x, bus.cs_n_x, bus.rw_x, bus.addr_x, bus.data_x};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {phi2_s, cs_n_s, rw_s, addr_s, data_s} = sync_q[SYNC_STAGES-1];

  // PHI2 filter: flt_cnt counts consecutive samples disagreeing with phi2_f;
  // the edge is accepted on the PHI2_FILTER-th such sample.
  logic          phi2_f;
  logic [FW-1:0] flt_cnt;
  logic          acc_edge, acc_rise, acc_fall;

  assign acc_edge = (phi2_s != phi2_f) && (flt_cnt == FW'(PHI2_FILTER - 1));
  assign acc_rise = acc_edge &  phi2_s;
  assign acc_fall = acc_edge & ~phi2_s;

  always_ff @(posedge clk) begin
    if (res) begin
      phi2_f  <= 1'b0;
      flt_cnt <= '0;
    end else if (acc_edge) begin
      phi2_f  <= phi2_s;
      flt_cnt <= '0;
    end else if (phi2_s != phi2_f) begin
      flt_cnt <= flt_cnt + 1'b1;
    end else begin
      flt_cnt <= '0;
    end
  end

  // Idle counter: saturating count of cycles since the last accepted edge.
  logic [7:0] idle_q, idle_n;
  logic       timeout;

  always_comb begin
    idle_n = idle_q;
    if (acc_edge)                           idle_n = '0;
    else if (idle_q != 8'(PHI2_TIMEOUT))    idle_n = idle_q + 8'd1;
  end

  assign timeout = (idle_n == 8'(PHI2_TIMEOUT));

  state_t        state;
  logic [7:0]    cnt;
  logic [HW-1:0] hold;
  logic [3:0]    phase_q;
  logic [4:0]    addr_q;
  logic [7:0]    data_q;
  logic          we_q, oe_q, data_oe_q, lost_q, short_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= SYNC;
      cnt       <= '0;
      idle_q    <= '0;
      hold      <= '0;
      phase_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      oe_q      <= 1'b0;
      data_oe_q <= 1'b0;
      lost_q    <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      idle_q  <= idle_n;
      lost_q  <= timeout;
      phase_q <= '0;

      case (state)
        SYNC: begin
          // Only a fall gives a reliable cycle boundary; rises are ignored.
          if (acc_fall) begin
            phase_q <= PH1;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            state   <= LOW;
          end
        end
        LOW: begin
          if (acc_rise) begin
            phase_q <= PH12;
            cnt     <= '0;
            state   <= HIGH_WAIT;
          end
        end
        HIGH_WAIT: begin
          if (acc_fall) begin
            // High phase ended before the pins were trusted: no access.
            phase_q <= PH1;
            short_q <= 1'b1;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            state   <= LOW;
          end else if (cnt == 8'(PHI2_SETTLE - 1)) begin
            phase_q <= PH2;
            addr_q  <= addr_s;
            data_q  <= data_s;
            we_q    <= ~cs_n_s & ~rw_s;
            oe_q    <= ~cs_n_s &  rw_s;
            state   <= HIGH_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HIGH_DONE: begin
          if (acc_fall) begin
            phase_q <= PH1;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            state   <= LOW;
          end else if (phase_q == PH2) begin
            phase_q <= PH21;
          end
        end
        default: state <= SYNC;
      endcase

      if (timeout) state <= SYNC;

      // Transceiver enable: opens after a read PHI2 strobe, closes DOUT_HOLD
      // cycles after the accepted fall (hold == 1 marks the last hold cycle).
      if (timeout) begin
        data_oe_q <= 1'b0;
        hold      <= '0;
      end else begin
        if (acc_fall)       hold <= HW'(DOUT_HOLD);
        else if (hold != 0) hold <= hold - 1'b1;
        if (hold == HW'(1) && !acc_fall)  data_oe_q <= 1'b0;
        else if (phase_q == PH2 && oe_q)  data_oe_q <= 1'b1;
      end
    end
  end

  assign bus.phase     = phase_q;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.we        = we_q;
  assign bus.oe        = oe_q;
  assign bus.data_oe   = data_oe_q;
  assign bus.phi2_lost = lost_q;
  assign bus.short_err = short_q;
endmodule

// File: tb/tb_sid_bus_if.sv
module tb_sid_bus_if;
  localparam int SETTLE = 8;
  localparam int HOLD   = 4;
  localparam int TMO    = 255;
  // bus word layout: {cs_n, rw, addr[4:0], data[7:0]}
  localparam logic [14:0] IDLE = {1'b1, 1'b1, 5'h00, 8'h00};
  localparam logic [14:0] WR   = {1'b0, 1'b0, 5'h18, 8'h0F};
  localparam logic [14:0] RD   = {1'b0, 1'b1, 5'h1B, 8'hA5};

  logic clk = 1'b0;
  logic res = 1'b1;
  sid_bus_if_if bus();
  sid_bus_if dut (.clk(clk), .res(res), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: edge-timestamp view of the bus cycle.
  int          n = 0;
  logic [3:0]  rph;          // raw PHI2 samples, rph[0] = previous edge
  logic [14:0] bsh0, bsh1;   // raw bus samples one and two edges back
  logic        f;            // accepted PHI2 level
  bit          synced, high, p2done;
  int          rise_e, p2_e, fall_e, acc_e;
  logic [3:0]  e_phase;
  logic [4:0]  e_addr;
  logic [7:0]  e_data;
  logic        e_we, e_oe, e_doe, e_lost, e_short;

  // Directed-test observations of the DUT.
  int         n_ph1, n_ph12, n_ph2, n_ph21, n_doe;
  logic [4:0] c_addr;
  logic [7:0] c_data;
  logic       c_we, c_oe, c_we1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r_res, input logic r_phi2, input logic [14:0] r_bus);
    logic acc, rise, fall, po;
    logic [3:0] pp;
    logic [14:0] b;
    n++;
    if (r_res) begin
      rph = '0; bsh0 = '0; bsh1 = '0; f = 1'b0;
      synced = 0; high = 0; p2done = 0;
      fall_e = -1000; acc_e = n;
      e_phase = '0; e_addr = '0; e_data = '0;
      e_we = 0; e_oe = 0; e_doe = 0; e_lost = 0; e_short = 0;
      return;
    end
    pp = e_phase;
    po = e_oe;
    // three consecutive synchronised samples disagreeing with f flip it
    acc = (rph[1] == rph[2]) && (rph[2] == rph[3]) && (rph[1] != f);
    b = bsh1;
    rph = {rph[2:0], r_phi2};
    bsh1 = bsh0;
    bsh0 = r_bus;
    if (acc) begin f = ~f; acc_e = n; end
    rise = acc && f;
    fall = acc && !f;
    e_phase = '0;
    if (!synced) begin
      if (fall) begin e_phase = 4'b0001; synced = 1; high = 0; end
    end else if (high) begin
      if (fall) begin
        e_phase = 4'b0001;
        if (!p2done) e_short = 1;
        high = 0;
      end else if (!p2done && n - rise_e == SETTLE) begin
        e_phase = 4'b0100; p2done = 1; p2_e = n;
        e_addr = b[12:8]; e_data = b[7:0];
        e_we = !b[14] && !b[13];
        e_oe = !b[14] && b[13];
      end else if (p2done && n == p2_e + 1) begin
        e_phase = 4'b1000;
      end
    end else if (rise) begin
      e_phase = 4'b0010; high = 1; rise_e = n; p2done = 0;
    end
    if (e_phase == 4'b0001) begin e_we = 0; e_oe = 0; end
    if (fall) fall_e = n;
    e_lost = (n - acc_e) >= TMO;
    if (e_lost) begin synced = 0; high = 0; end
    if (e_lost)                      e_doe = 0;
    else if (n == fall_e + HOLD)     e_doe = 0;
    else if (pp == 4'b0100 && po)    e_doe = 1;
  endtask

  task automatic clr();
    n_ph1 = 0; n_ph12 = 0; n_ph2 = 0; n_ph21 = 0; n_doe = 0;
    c_addr = 'x; c_data = 'x; c_we = 1'bx; c_oe = 1'bx; c_we1 = 1'bx;
  endtask

  // One clock: drive pins, take the edge, advance the model, compare.
  task automatic cyc(input logic r, input logic p, input logic [14:0] b);
    res = r;
    bus.phi2_x = p;
    {bus.cs_n_x, bus.rw_x, bus.addr_x, bus.data_x} = b;
    @(posedge clk);
    model_edge(r, p, b);
    #1;
    chk("phase",     32'(bus.phase),     32'(e_phase));
    chk("addr",      32'(bus.addr),      32'(e_addr));
    chk("data",      32'(bus.data),      32'(e_data));
    chk("we",        32'(bus.we),        32'(e_we));
    chk("oe",        32'(bus.oe),        32'(e_oe));
    chk("data_oe",   32'(bus.data_oe),   32'(e_doe));
    chk("phi2_lost", 32'(bus.phi2_lost), 32'(e_lost));
    chk("short_err", 32'(bus.short_err), 32'(e_short));
    case (bus.phase)
      4'b0001: begin n_ph1++; c_we1 = bus.we; end
      4'b0010: n_ph12++;
      4'b0100: begin n_ph2++; c_addr = bus.addr; c_data = bus.data; c_we = bus.we; c_oe = bus.oe; end
      4'b1000: n_ph21++;
      default: ;
    endcase
    if (bus.data_oe) n_doe++;
  endtask

  task automatic bus_cycle(input int hi, input int lo, input logic [14:0] b, input bit glitch);
    for (int i = 0; i < hi; i++) cyc(1'b0, 1'b1, b);
    for (int i = 0; i < lo; i++) cyc(1'b0, glitch && (i == 5 || i == 6), b);
  endtask

  initial begin
    int lat, lost_at;
    logic [14:0] rb;

    // reset with PHI2 high
    cyc(1'b1, 1'b1, IDLE);
    cyc(1'b1, 1'b1, IDLE);
    chk("reset_outputs", {bus.phase, bus.addr, bus.data, bus.we, bus.oe,
                          bus.data_oe, bus.phi2_lost, bus.short_err}, 32'd0);

    // first fall: PHI1 is the first strobe, 5 clocks after the raw fall
    clr();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, IDLE);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cyc(1'b0, 1'b0, IDLE);
      if (bus.phase == 4'b0001) lat = i;
    end
    chk("ph1_latency", lat, 5);
    chk("no_strobe_before_ph1", n_ph12 + n_ph2 + n_ph21, 0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, IDLE);

    // write cycle at 1 MHz (12 high / 12 low)
    clr();
    bus_cycle(12, 12, WR, 0);
    chk("wr_addr", c_addr, 5'h18);
    chk("wr_data", c_data, 8'h0F);
    chk("wr_we", c_we, 1);
    chk("wr_oe", c_oe, 0);
    chk("wr_data_oe_cycles", n_doe, 0);
    chk("wr_we_at_ph1", c_we1, 0);
    chk("wr_strobe_counts", {n_ph1[7:0], n_ph12[7:0], n_ph2[7:0], n_ph21[7:0]}, 32'h01010101);

    // read: data_oe from PHI2+1 until 4 after the accepted fall = 7 cycles
    clr();
    bus_cycle(12, 12, RD, 0);
    chk("rd_addr", c_addr, 5'h1B);
    chk("rd_oe", c_oe, 1);
    chk("rd_we", c_we, 0);
    chk("rd_data_oe_cycles", n_doe, 7);

    // 2-cycle glitch inside a low phase
    clr();
    for (int i = 0; i < 6; i++)  cyc(1'b0, 1'b0, IDLE);
    for (int i = 0; i < 2; i++)  cyc(1'b0, 1'b1, IDLE);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, IDLE);
    chk("glitch_strobes", n_ph1 + n_ph12 + n_ph2 + n_ph21, 0);

    // short high phase (6 cycles < PHI2_SETTLE)
    clr();
    bus_cycle(6, 12, RD, 0);
    chk("short_err", bus.short_err, 1);
    chk("short_no_ph2", n_ph2, 0);
    chk("short_we_oe", {bus.we, bus.oe}, 2'b00);
    chk("short_ph1", n_ph1, 1);

    // PHI2 stuck low: accepted fall was 7 edges before this loop, so the
    // idle count reaches 255 on loop edge 248
    clr();
    lost_at = 0;
    for (int i = 1; i <= 300; i++) begin
      cyc(1'b0, 1'b0, IDLE);
      if (bus.phi2_lost && lost_at == 0) lost_at = i;
    end
    chk("lost_at", lost_at, 248);
    chk("lost_data_oe", bus.data_oe, 0);
    clr();
    bus_cycle(12, 12, IDLE, 0);
    chk("lost_cleared", bus.phi2_lost, 0);
    chk("resync_ph1", n_ph1, 1);
    chk("resync_no_ph2", n_ph2, 0);

    // randomized bus cycles
    for (int k = 0; k < 40; k++) begin
      rb = 15'($urandom);
      bus_cycle(int'($urandom_range(3, 16)), int'($urandom_range(6, 16)), rb,
                $urandom_range(0, 3) == 0);
    end

    // reset one cycle after a read PHI2 strobe
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, IDLE);
    clr();
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, RD);
    cyc(1'b0, 1'b0, RD);
    chk("pre_rst_ph2", bus.phase, 4'b0100);
    chk("pre_rst_oe", bus.oe, 1);
    cyc(1'b1, 1'b0, RD);
    chk("mid_rst_outputs", {bus.phase, bus.addr, bus.data, bus.we, bus.oe,
                            bus.data_oe, bus.phi2_lost, bus.short_err}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, RD);
    chk("rst_no_ph21", n_ph21, 0);

    // resume normal operation after reset
    bus_cycle(12, 12, IDLE, 0);
    bus_cycle(12, 12, WR, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sid_bus_if.md
Name: sid_bus_if

Overview:
- Front-end stage directly upstream of the SID core, in the system clock domain.
- Synchronises the raw, asynchronous 6510-side bus pins (PHI2, CS_n, R/W_n, A4..A0, D7..D0) into the system clock domain and deglitches PHI2.
- Produces the one-hot sub-cycle phase strobes and a registered bus transaction (addr/data/we/oe) that the core consumes at the PHI2 strobe.
- Generates the data-bus output enable, with hold time, for the external data-bus transceiver.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers, applied to every *_x pin.
- PHI2_FILTER, 3: consecutive identical synchronised samples required before a PHI2 level change is accepted.
- PHI2_SETTLE, 8: clk cycles after an accepted PHI2 rise before bus pins are sampled; legal range 1..200.
- DOUT_HOLD, 4: clk cycles data_oe stays high after an accepted PHI2 fall.
- PHI2_TIMEOUT, 255: clk cycles without an accepted PHI2 edge before phi2_lost is raised; the counter is 8 bits wide.

Ports:
- clk  in  1  system clock; sole clock.
- res  in  1  synchronous, active-high reset.
- phi2_x  in  1  raw PHI2 pin.
- cs_n_x  in  1  raw chip select, active low.
- rw_x  in  1  raw R/W_n (1 = read).
- addr_x  in  5  raw A4..A0.
- data_x  in  8  raw D7..D0.
- phase  out  4  one-hot strobes: bit0 PHI1, bit1 PHI1_PHI2, bit2 PHI2, bit3 PHI2_PHI1.
- addr  out  5  registered address.
- data  out  8  registered write data.
- we  out  1  write request.
- oe  out  1  read request.
- data_oe  out  1  enable for the external data-bus driver.
- phi2_lost  out  1  PHI2 absent or stuck.
- short_err  out  1  sticky; set when a PHI2 high phase ends before the PHI2 strobe.

Behaviour:
- Reset (synchronous, res=1 at a clk edge):
  - All outputs are 0.
  - Synchroniser and filter state are cleared; phi2_f = 0.
  - FSM enters SYNC; counters are 0.
  - Reset mid-transaction aborts it; no strobe fires in the reset cycle.
- Synchroniser and filter:
  - phi2_f adopts phi2_s only after PHI2_FILTER consecutive samples differ from the current phi2_f.
  - Latency from raw edge to accepted edge = SYNC_STAGES + PHI2_FILTER clk cycles (5 with defaults).
  - Pulses shorter than PHI2_FILTER cycles are ignored.
- FSM states: SYNC, LOW, HIGH_WAIT, HIGH_DONE.
  - SYNC: emits no strobes. An accepted fall goes to LOW and pulses PHI1. An accepted rise is ignored.
  - LOW: an accepted rise pulses PHI1_PHI2, clears cnt, and goes to HIGH_WAIT.
  - HIGH_WAIT: cnt increments each cycle.
    - When cnt == PHI2_SETTLE-1: pulse PHI2 and go to HIGH_DONE.
    - In that same cycle, addr and data load from the synchronised pins, we <= !cs_n & !rw, and oe <= !cs_n & rw.
    - If an accepted fall arrives before the PHI2 strobe: set short_err, pulse PHI1, go to LOW; no PHI2 or PHI2_PHI1 for that cycle, and we/oe stay 0.
  - HIGH_DONE: PHI2_PHI1 pulses on the cycle after PHI2. An accepted fall pulses PHI1 and goes to LOW.
- Strobe rules:
  - Each strobe lasts exactly one clk cycle.
  - At most one phase bit is high in any cycle.
- Transaction outputs:
  - addr/data hold their values until the next PHI2 strobe.
  - we/oe clear on the PHI1 strobe, so there is at most one access per bus cycle.
- data_oe:
  - Rises on the cycle after a PHI2 strobe with oe = 1.
  - Falls DOUT_HOLD cycles after the accepted PHI2 fall.
  - Falls immediately on reset or on phi2_lost.
- Timeout:
  - The idle counter clears on every accepted PHI2 edge and saturates at PHI2_TIMEOUT.
  - On reaching PHI2_TIMEOUT: phi2_lost = 1 and FSM goes to SYNC.
  - phi2_lost clears on the next accepted edge.
  - Resynchronisation still requires an accepted fall.
- short_err clears only on reset.

Test Plan:
- Reset then a 1 MHz PHI2 (clk = 24 MHz, 12 cycles high) -> first strobe is PHI1, 5 clk after the first raw fall; then PHI1_PHI2, PHI2, PHI2_PHI1 in order, one cycle each, never overlapping.
- Write with cs_n=0, rw=0, addr=0x18, data=0x0F -> at the PHI2 strobe, addr=0x18, data=0x0F, we=1, oe=0; data_oe stays 0; we clears at the next PHI1.
- Read with cs_n=0, rw=1, addr=0x1B -> oe=1 at the PHI2 strobe; data_oe=1 from the next cycle until 4 clk after the accepted fall.
- 2-cycle glitch on PHI2 -> no strobes, FSM unchanged. A high phase of 6 accepted cycles (< PHI2_SETTLE) -> short_err=1, no PHI2 strobe, we=oe=0.
- PHI2 held low for 300 clk -> phi2_lost=1 at idle-count 255 and data_oe=0; after a PHI2 rise and fall, phi2_lost=0 and PHI1 fires.
- res=1 asserted one cycle after a PHI2 strobe for a read -> all outputs 0 in the next cycle, including data_oe; the following PHI2_PHI1 is not emitted.
